// File: rtl/mc_pkg.sv
// Shared constants for the RV32I multicycle controller: states, opcodes, select and ALU codes.
package mc_pkg;

  localparam int unsigned STATE_W = 4;

  // FSM state encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  // Supported opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Mux select codes
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU control decoder: fixed add/sub, or funct3-driven operation for R/I instructions.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alucontrol
);

  // Select ALU operation; sub only for R-type with funct7b5 set
  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alucontrol = (i_funct7b5 & i_op5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alucontrol = ALU_SLT;
          3'b110:  o_alucontrol = ALU_OR;
          3'b111:  o_alucontrol = ALU_AND;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I sequencer: Moore FSM driving strobes, mux selects and ALU control.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit EXT_BRANCH      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       halted
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [1:0]         w_aluop;
  logic               w_pcwrite;
  logic               w_memwrite;
  logic               w_irwrite;
  logic               w_regwrite;
  logic               w_taken;

  // State register; reset returns to FETCH, abandoning any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Branch condition from funct3; extended compares optional
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = EXT_BRANCH & ~Zero;
      3'b100:  w_taken = EXT_BRANCH & Lt;
      3'b101:  w_taken = EXT_BRANCH & ~Lt;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next     = r_state;
    w_aluop    = ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REG;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_BRANCH:         w_next = S_BRANCH;
          default:           w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        w_aluop   = ALUOP_SUB;
        w_pcwrite = w_taken;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are suppressed for as long as reset is asserted
  assign PCWrite  = w_pcwrite  & ~reset;
  assign MemWrite = w_memwrite & ~reset;
  assign IRWrite  = w_irwrite  & ~reset;
  assign RegWrite = w_regwrite & ~reset;

  assign ImmSrc = imm_src(op);

  mc_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_op5        (op[5]),
    .o_alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: expected per-cycle output traces built from instruction semantics.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Lt;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .halted(halted)
  );

  always #5 clk = ~clk;

  // Observed vector: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,halted}
  logic [16:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halted};

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic        z;
    logic        lt;
    logic [16:0] v;
  } step_t;

  step_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %05h exp %05h", tag, got, exp);
    end
  endtask

  // Immediate format each instruction class uses
  function automatic logic [1:0] m_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic operation an R/I instruction asks for
  function automatic logic [2:0] m_alu(input bit is_r);
    case (cur_f3)
      3'd0:    return (is_r && cur_f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit m_taken(input logic z, input logic lt);
    case (cur_f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [16:0] vec(input bit pcw, input bit adr, input bit mw, input bit irw,
                                      input bit rw, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] alu, input bit h);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, m_imm(cur_op), alu, h};
  endfunction

  task automatic push_zl(input logic mr, input logic z, input logic lt, input logic [16:0] v);
    q.push_back('{op: cur_op, f3: cur_f3, f7: cur_f7, mr: mr, z: z, lt: lt, v: v});
  endtask

  task automatic push(input logic mr, input logic [16:0] v);
    push_zl(mr, 1'($urandom), 1'($urandom), v);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected cycle-by-cycle outputs of one instruction
  task automatic gen_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fst, input int mst, input logic bz, input logic blt);
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    for (int i = 0; i < fst; i++) push(1'b0, vec(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0));
    push(1'b1, vec(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0));
    push(rb(), vec(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0));
    case (o)
      7'b0000011: begin
        push(rb(), vec(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0));
        for (int i = 0; i < mst; i++) push(1'b0, vec(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0));
        push(1'b1, vec(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0));
        push(rb(), vec(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,0));
      end
      7'b0100011: begin
        push(rb(), vec(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0));
        for (int i = 0; i < mst; i++) push(1'b0, vec(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0));
        push(1'b1, vec(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0));
      end
      7'b0110011: begin
        push(rb(), vec(0,0,0,0,0,2'b00,2'b10,2'b00,m_alu(1),0));
        push(rb(), vec(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0));
      end
      7'b0010011: begin
        push(rb(), vec(0,0,0,0,0,2'b00,2'b10,2'b01,m_alu(0),0));
        push(rb(), vec(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0));
      end
      7'b1101111: begin
        push(rb(), vec(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,0));
        push(rb(), vec(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0));
      end
      7'b1100011:
        push_zl(rb(), bz, blt, vec(m_taken(bz, blt),0,0,0,0,2'b00,2'b10,2'b00,3'b001,0));
      default: ;
    endcase
  endtask

  // Drive queued steps one per cycle, checking outputs mid-cycle
  task automatic run(input string name);
    int n;
    n = 0;
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      @(negedge clk);
      op = s.op; funct3 = s.f3; funct7b5 = s.f7;
      mem_ready = s.mr; Zero = s.z; Lt = s.lt;
      #1;
      check_eq($sformatf("%s[%0d]", name, n), obs, s.v);
      n++;
    end
  endtask

  // Assert reset for one cycle; strobes must drop immediately even with mem_ready high
  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check_eq(name, obs, vec(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0));
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0; Lt = 1'b0;
    op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    cur_op = op; cur_f3 = funct3; cur_f7 = funct7b5;
    #1;
    check_eq("reset", obs, vec(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0));
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;

    gen_instr(7'b0000011, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0); run("lw");
    gen_instr(7'b0100011, 3'd2, 1'b0, 0, 2, 1'b0, 1'b0); run("sw_stall");
    gen_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0); run("beq_z1");
    gen_instr(7'b1100011, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1); run("beq_z0");
    gen_instr(7'b1100011, 3'd1, 1'b0, 0, 0, 1'b1, 1'b0); run("bne_z1");
    gen_instr(7'b1100011, 3'd4, 1'b0, 0, 0, 1'b0, 1'b1); run("blt_lt1");
    gen_instr(7'b1100011, 3'd5, 1'b0, 0, 0, 1'b0, 1'b1); run("bge_lt1");
    gen_instr(7'b1100011, 3'd2, 1'b0, 0, 0, 1'b1, 1'b1); run("br_f3_2");
    gen_instr(7'b0110011, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0); run("sub");
    gen_instr(7'b0010011, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0); run("addi_f7");
    gen_instr(7'b1101111, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0); run("jal");
    gen_instr(7'b0000011, 3'd2, 1'b0, 2, 3, 1'b0, 1'b0); run("lw_stall");

    for (int k = 0; k < 150; k++) begin
      logic [6:0] o;
      logic [2:0] f3;
      case ($urandom_range(0, 5))
        0:       o = 7'b0000011;
        1:       o = 7'b0100011;
        2:       o = 7'b0110011;
        3:       o = 7'b0010011;
        4:       o = 7'b1101111;
        default: o = 7'b1100011;
      endcase
      f3 = 3'($urandom);
      gen_instr(o, f3, rb(), $urandom_range(0, 2), $urandom_range(0, 2), rb(), rb());
      run($sformatf("rnd%0d", k));
    end

    // Unsupported opcode halts; only reset recovers
    gen_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) push(rb(), vec(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1));
    run("halt");
    do_reset("halt_rst");
    gen_instr(7'b0010011, 3'd7, 1'b0, 0, 0, 1'b0, 1'b0); run("after_halt");

    // Reset in the middle of a stalled store
    gen_instr(7'b0100011, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0);
    void'(q.pop_back());
    push(1'b0, vec(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0));
    run("sw_pre_rst");
    do_reset("sw_rst");
    gen_instr(7'b0110011, 3'd6, 1'b0, 1, 0, 1'b0, 1'b0); run("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
